// File: rtl/tft_pkg.sv
// Shared timing defaults, phase/record types and frame-size helpers for the
// 800x480 TFT pixel-timing path.
package tft_pkg;

   localparam int unsigned DEF_H_ACTIVE = 800;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_H_SYNC   = 48;
   localparam int unsigned DEF_H_BP     = 88;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 13;
   localparam int unsigned DEF_V_SYNC   = 3;
   localparam int unsigned DEF_V_BP     = 29;
   localparam int unsigned CW           = 16;

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FP,
      PH_SYNC,
      PH_BP
   } phase_e;

   // Same byte layout as the frame_storage RAM word.
   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic fstart;
      logic fdone;
   } ctl_t;

   function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/tft_axis_counter.sv
// One timing axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase decode.
module tft_axis_counter
   import tft_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic          i_step,
   output logic [CW-1:0] o_cnt,
   output logic          o_wrap,
   output phase_e        o_phase
);

   localparam int unsigned   TOTAL  = h_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
   localparam logic [CW-1:0] B_FP   = CW'(ACTIVE);
   localparam logic [CW-1:0] B_SYNC = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] B_BP   = CW'(ACTIVE + FP + SYNC);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      o_wrap = i_step && (cnt_q == LAST);
      cnt_d  = cnt_q;
      if (!i_en) begin
         cnt_d = '0;
      end else if (i_step) begin
         cnt_d = o_wrap ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      if (cnt_q < B_FP) begin
         o_phase = PH_ACTIVE;
      end else if (cnt_q < B_SYNC) begin
         o_phase = PH_FP;
      end else if (cnt_q < B_BP) begin
         o_phase = PH_SYNC;
      end else begin
         o_phase = PH_BP;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/tft_timing_gen.sv
// Pixel-timing master: issues coordinates to frame_storage and re-aligns the
// returned colour with delayed HSYNC/VSYNC/DE and frame markers at the pins.
module tft_timing_gen
   import tft_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   output logic [CW-1:0] o_row_pixel,
   output logic [CW-1:0] o_col_pixel,
   input  logic [7:0]    i_Red,
   input  logic [7:0]    i_Green,
   input  logic [7:0]    i_Blue,
   output logic          o_hsync_n,
   output logic          o_vsync_n,
   output logic          o_de,
   output logic [7:0]    o_r,
   output logic [7:0]    o_g,
   output logic [7:0]    o_b,
   output logic          o_frame_start,
   output logic          o_frame_done
);

   localparam logic [CW-1:0] H_LAST_ACT = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] V_LAST_ACT = CW'(V_ACTIVE - 1);

   logic [CW-1:0] h_cnt, v_cnt;
   logic          h_wrap, unused_v_wrap;
   phase_e        h_ph, v_ph;
   logic          act;
   ctl_t          ctl_d;
   ctl_t          ctl_q [RD_LAT+1];
   rgb_t          rgb_d, rgb_q;

   tft_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_step  (1'b1),
      .o_cnt   (h_cnt),
      .o_wrap  (h_wrap),
      .o_phase (h_ph)
   );

   tft_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_step  (h_wrap),
      .o_cnt   (v_cnt),
      .o_wrap  (unused_v_wrap),
      .o_phase (v_ph)
   );

   // Gating with i_en makes a disabled panel look idle in the same cycle.
   always_comb begin
      act          = i_en && (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
      ctl_d        = '0;
      ctl_d.hsync  = i_en && (h_ph == PH_SYNC);
      ctl_d.vsync  = i_en && (v_ph == PH_SYNC);
      ctl_d.de     = act;
      ctl_d.fstart = act && (h_cnt == '0) && (v_cnt == '0);
      ctl_d.fdone  = act && (h_cnt == H_LAST_ACT) && (v_cnt == V_LAST_ACT);
      o_col_pixel  = act ? h_cnt : '0;
      o_row_pixel  = act ? v_cnt : '0;
   end

   // Stage RD_LAT-1 holds the control word whose colour is on i_* right now.
   always_comb begin
      rgb_d = '0;
      if (ctl_q[RD_LAT-1].de) begin
         rgb_d = '{red: i_Red, green: i_Green, blue: i_Blue};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i <= RD_LAT; i++) begin
            ctl_q[i] <= '0;
         end
         rgb_q <= '0;
      end else begin
         ctl_q[0] <= ctl_d;
         for (int unsigned i = 1; i <= RD_LAT; i++) begin
            ctl_q[i] <= ctl_q[i-1];
         end
         rgb_q <= rgb_d;
      end
   end

   assign o_hsync_n     = ~ctl_q[RD_LAT].hsync;
   assign o_vsync_n     = ~ctl_q[RD_LAT].vsync;
   assign o_de          = ctl_q[RD_LAT].de;
   assign o_frame_start = ctl_q[RD_LAT].fstart;
   assign o_frame_done  = ctl_q[RD_LAT].fdone;
   assign o_r           = rgb_q.red;
   assign o_g           = rgb_q.green;
   assign o_b           = rgb_q.blue;

endmodule
